// File: rtl/loader_write_queue.sv
// ============================================================================
//  Module      : loader_write_queue
//  Description : Queues ROM-loader byte writes from the NES clock domain and
//                replays them to the SDRAM write port. Each write goes out in
//                a fixed clock-enable slot and is held for one full enable
//                period. The block also generates the divided clock-enable
//                used by the core.
//
//  Ports
//    clk        in   NES clock
//    reset      in   asynchronous, active-high reset
//    enable     in   download active; low flushes the queue
//    in_write   in   one-cycle write strobe from the loader
//    in_addr    in   loader write address  [ADDR_W]
//    in_data    in   loader write data     [DATA_W]
//    in_ready   out  queue not full (registered full flag)
//    ce         out  slot strobe, one cycle in every CE_DIV cycles
//    mem_write  out  write request to the SDRAM controller
//    mem_addr   out  write address         [ADDR_W]
//    mem_data   out  write data            [DATA_W]
//    level      out  queue occupancy       [$clog2(DEPTH)+1]
//    overflow   out  sticky: a write was dropped while full
//    busy       out  queue non-empty or mem_write high
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module loader_write_queue #(
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int CE_DIV   = 4,
    parameter int CE_PHASE = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       in_write,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       ce,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       busy
);

    localparam int C_CNT_W = $clog2(CE_DIV);
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_LVL_W = C_PTR_W + 1;
    localparam int C_ENT_W = ADDR_W + DATA_W;

    localparam logic [C_CNT_W-1:0] C_PHASE = C_CNT_W'(CE_PHASE);
    localparam logic [C_LVL_W-1:0] C_FULL  = C_LVL_W'(DEPTH);

    // Registered state
    logic [C_CNT_W-1:0] cnt_q,       cnt_d;
    logic [C_PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [C_LVL_W-1:0] level_q,     level_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]  mem_data_q,  mem_data_d;
    logic               overflow_q,  overflow_d;
    logic               enable_q,    enable_d;

    // Queue storage: plain RAM, contents only meaningful below level_q
    logic [C_ENT_W-1:0] fifo_q [DEPTH];

    // Combinational helpers
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_ce;
    logic [C_ENT_W-1:0] w_head;

    assign w_full  = (level_q == C_FULL);
    assign w_empty = (level_q == '0);
    assign w_ce    = (cnt_q == C_PHASE);
    // Full and empty come from registered state only: a write arriving while
    // full is dropped even if the slot frees an entry this cycle, and a write
    // into an empty queue cannot be popped until the following slot.
    assign w_push  = in_write && enable && !w_full;
    assign w_pop   = w_ce && enable && !w_empty;
    assign w_head  = fifo_q[rd_ptr_q];

    always_comb begin
        cnt_d       = cnt_q + C_CNT_W'(1);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        overflow_d  = overflow_q;
        enable_d    = enable;

        if (!enable) begin
            // Flush takes effect immediately rather than at the next slot;
            // address/data are left alone since mem_write already drops.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            mem_write_d = 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d   = rd_ptr_q + C_PTR_W'(1);
                mem_addr_d = w_head[C_ENT_W-1:DATA_W];
                mem_data_d = w_head[DATA_W-1:0];
            end
            // Outputs only change on a slot, so each write is held CE_DIV cycles
            if (w_ce) begin
                mem_write_d = !w_empty;
            end
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + C_LVL_W'(1);
                2'b01:   level_d = level_q - C_LVL_W'(1);
                default: level_d = level_q;
            endcase
        end

        // A fresh download session starts with a clean overflow flag
        if (enable && !enable_q) begin
            overflow_d = 1'b0;
        end
        if (in_write && enable && w_full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            overflow_q  <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            overflow_q  <= overflow_d;
            enable_q    <= enable_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= {in_addr, in_data};
        end
    end

    assign in_ready  = !w_full;
    assign ce        = w_ce;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign busy      = !w_empty || mem_write_q;

endmodule

`default_nettype wire

// File: tb/tb_loader_write_queue.sv
// ============================================================================
//  Module      : tb_loader_write_queue
//  Description : Directed bench for loader_write_queue. Stimulus pushes the
//                writes it expects to reach memory into a scoreboard queue;
//                a monitor compares every newly issued memory write against
//                the head of that queue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_loader_write_queue;

    localparam int ADDR_W   = 22;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 4;
    localparam int CE_DIV   = 4;
    localparam int CE_PHASE = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                in_write;
    logic [ADDR_W-1:0]   in_addr;
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;
    logic                ce;
    logic                mem_write;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic [2:0]          level;
    logic                overflow;
    logic                busy;

    loader_write_queue #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .CE_DIV   (CE_DIV),
        .CE_PHASE (CE_PHASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_write  (in_write),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ce        (ce),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .level     (level),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int k      = 0;   // posedges since reset release; counter phase = k % 4

    logic [ADDR_W+DATA_W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    // Inputs change and outputs are sampled at negedges
    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    task automatic drive(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit issued);
        in_write = 1'b1;
        in_addr  = a;
        in_data  = d;
        if (issued) exp_q.push_back({a, d});
    endtask

    // Monitor: a slot seen at one negedge with mem_write high at the next
    // means a new write was issued on the edge in between.
    logic ce_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            ce_prev = 1'b0;
        end else begin
            if (ce_prev && mem_write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h expected none (k=%0d)", {mem_addr, mem_data}, k);
                end else begin
                    chk("mem_entry", 32'({mem_addr, mem_data}), 32'(exp_q.pop_front()));
                end
            end
            ce_prev = ce;
        end
    end

    logic [ADDR_W-1:0] va [6];
    logic [DATA_W-1:0] vd [6];
    bit                vi [6];

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        in_write = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ce",        32'(ce),        32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_level",     32'(level),     32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);

        reset = 1'b0;
        k     = 0;

        // Idle: ce on phase 3 only, nothing written
        for (int i = 0; i < 12; i++) begin
            chk("idle_ce",        32'(ce),        32'((k % 4) == 3));
            chk("idle_mem_write", 32'(mem_write), 32'd0);
            tick();
        end
        chk("idle_level",    32'(level),    32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_busy",     32'(busy),     32'd0);

        // Single push at phase 0 (k=12); issued on the edge after phase 3
        drive(22'h000010, 8'hA5, 1'b1);
        tick();
        in_write = 1'b0;
        chk("single_level", 32'(level), 32'd1);
        chk("single_busy",  32'(busy),  32'd1);
        chk("single_latency_pre", 32'(mem_write), 32'd0);
        while (k < 16) tick();
        for (int i = 0; i < 4; i++) begin
            chk("single_hold_wr",   32'(mem_write), 32'd1);
            chk("single_hold_addr", 32'(mem_addr),  32'h10);
            chk("single_hold_data", 32'(mem_data),  32'hA5);
            tick();
        end
        chk("single_end_wr",    32'(mem_write), 32'd0);
        chk("single_end_level", 32'(level),     32'd0);
        chk("single_end_busy",  32'(busy),      32'd0);

        // Six back-to-back pushes starting on a slot cycle (k=23). The first
        // lands in an empty queue so it is not popped that slot; entries 1..4
        // fill the queue, entry 5 meets full at the next slot and is dropped
        // (the pop there does not rescue it), entry 6 then fits.
        while (k < 23) tick();
        for (int i = 0; i < 6; i++) begin
            va[i] = 22'h001000 + 22'(i);
            vd[i] = 8'hC0 + 8'(i);
            vi[i] = (i != 4);
        end
        for (int i = 0; i < 6; i++) begin
            drive(va[i], vd[i], vi[i]);
            tick();
            if (i == 3) begin
                chk("burst_in_ready_full", 32'(in_ready), 32'd0);
                chk("burst_level_full",    32'(level),    32'd4);
            end
            if (i == 4) begin
                chk("burst_overflow", 32'(overflow), 32'd1);
                chk("burst_level_5",  32'(level),    32'd3);
            end
            if (i == 5) begin
                chk("burst_level_6", 32'(level), 32'd4);
            end
        end
        in_write = 1'b0;
        while (k < 47) tick();
        chk("burst_last_wr",   32'(mem_write), 32'd1);
        chk("burst_last_data", 32'(mem_data),  32'hC5);
        tick();
        chk("burst_end_wr",    32'(mem_write), 32'd0);
        chk("burst_end_level", 32'(level),     32'd0);

        // Push on a slot cycle while holding one entry (k=48..52)
        drive(22'h3F0001, 8'h11, 1'b1);
        tick();
        in_write = 1'b0;
        while (k < 51) tick();
        chk("coinc_ce",       32'(ce),    32'd1);
        chk("coinc_level_pre", 32'(level), 32'd1);
        drive(22'h3F0002, 8'h22, 1'b1);
        tick();
        in_write = 1'b0;
        chk("coinc_level_same", 32'(level),    32'd1);
        chk("coinc_old_first",  32'(mem_data), 32'h11);
        while (k < 56) tick();
        chk("coinc_new_next",   32'(mem_data), 32'h22);
        chk("coinc_level_end",  32'(level),    32'd0);
        while (k < 60) tick();
        chk("coinc_end_wr", 32'(mem_write), 32'd0);

        // Flush with level=3 and mem_write high (k=64); only the first
        // entry gets issued before the flush.
        for (int i = 0; i < 4; i++) begin
            drive(22'h000100 + 22'(i), 8'hF0 + 8'(i), i == 0);
            tick();
        end
        in_write = 1'b0;
        chk("flush_pre_level", 32'(level),     32'd3);
        chk("flush_pre_wr",    32'(mem_write), 32'd1);
        enable = 1'b0;
        tick();
        chk("flush_wr",        32'(mem_write), 32'd0);
        chk("flush_level",     32'(level),     32'd0);
        chk("flush_busy",      32'(busy),      32'd0);
        chk("flush_data_hold", 32'(mem_data),  32'hF0);
        drive(22'h000200, 8'h55, 1'b0);   // ignored while enable is low
        tick();
        in_write = 1'b0;
        chk("disabled_level",    32'(level),    32'd0);
        chk("disabled_overflow", 32'(overflow), 32'd1);
        enable = 1'b1;
        tick();
        chk("reenable_overflow", 32'(overflow), 32'd0);
        while (k < 76) tick();
        chk("reenable_wr",    32'(mem_write), 32'd0);
        chk("reenable_level", 32'(level),     32'd0);

        // Async reset mid-burst: level=2, mem_write=1 at k=80
        for (int i = 0; i < 3; i++) begin
            drive(22'h2A0000 + 22'(i), 8'h40 + 8'(i), i == 0);
            tick();
        end
        in_write = 1'b0;
        tick();
        chk("mid_level", 32'(level),     32'd2);
        chk("mid_wr",    32'(mem_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_wr",       32'(mem_write), 32'd0);
        chk("async_level",    32'(level),     32'd0);
        chk("async_busy",     32'(busy),      32'd0);
        chk("async_addr",     32'(mem_addr),  32'd0);
        chk("async_data",     32'(mem_data),  32'd0);
        chk("async_in_ready", 32'(in_ready),  32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        k     = 0;
        for (int i = 0; i < 4; i++) begin
            chk("restart_ce", 32'(ce), 32'(i == 3));
            tick();
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
